// File: rtl/fetch_pkg.sv
// Shared types and defaults for the prefetching instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_ID   = 2'd1,
    REDIR_EX   = 2'd2
  } redirect_src_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries, plus its overflow checker.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type T = logic [63:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output T                       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           push_ok_s, pop_ok_s;

  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign head_o    = mem_q[rd_q];
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok_s) wr_d = wr_q + AW'(1'b1);
      else           wr_d = wr_q;
      if (pop_ok_s)  rd_d = rd_q + AW'(1'b1);
      else           rd_d = rd_q;
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1'b1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1'b1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_ok_s && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

module fetch_fifo_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic push_i,
  input logic full_i
);

  // A push into a full queue means the issue credit accounting is broken.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_i));

endmodule

// File: rtl/fetch_queue_if.sv
// Prefetching IF stage: issues up to DEPTH requests, queues responses, redirects on ID/EX.
// Optional combinational response bypass when the queue is empty: define FETCH_BYPASS_EN.
module fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = FETCH_XLEN,
  parameter int unsigned     IADDR_W  = 30,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               redirect_ID,
  input  logic [XLEN-1:0]    target_ID,
  input  logic               redirect_EX,
  input  logic [XLEN-1:0]    target_EX,
  output logic               IREQ,
  output logic [IADDR_W-1:0] IADDR,
  input  logic               IRDY,
  input  logic               IVALID,
  input  logic [XLEN-1:0]    IDATA,
  output logic               valid_IF,
  input  logic               ready_ID,
  output logic [XLEN-1:0]    instr_IF,
  output logic [XLEN-1:0]    PC_IF,
  output logic [XLEN-1:0]    PCadd4_IF
);

  localparam int unsigned     CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target_s;
  logic [CW-1:0]   outst_q, outst_d, discard_q, discard_d, count_s;
  logic [CW:0]     credit_s;
  logic            full_s, empty_s, issue_s, keep_s, push_s, pop_s, byp_s, redir_s;
  redirect_src_e   src_s;
  entry_t          head_s, push_entry_s;

  // EX redirects belong to the older instruction, so they win over ID.
  always_comb begin
    src_s    = REDIR_NONE;
    target_s = fetch_pc_q;
    if (redirect_EX) begin
      src_s    = REDIR_EX;
      target_s = target_EX;
    end else if (redirect_ID) begin
      src_s    = REDIR_ID;
      target_s = target_ID;
    end else begin
      src_s    = REDIR_NONE;
      target_s = fetch_pc_q;
    end
  end

  assign redir_s  = (src_s != REDIR_NONE);
  assign credit_s = {1'b0, count_s} + {1'b0, outst_q};
  assign IREQ     = RSTN & ~redir_s & (credit_s < DEPTH_C);
  assign IADDR    = fetch_pc_q[IADDR_W-1:0];
  assign issue_s  = IREQ & IRDY;
  assign keep_s   = IVALID & ~redir_s & (discard_q == '0);

`ifdef FETCH_BYPASS_EN
  assign byp_s    = keep_s & empty_s;
  assign instr_IF = byp_s ? IDATA : head_s.instr;
  assign PC_IF    = byp_s ? resp_pc_q : head_s.pc;
`else
  assign byp_s    = 1'b0;
  assign instr_IF = head_s.instr;
  assign PC_IF    = head_s.pc;
`endif

  assign valid_IF     = ~empty_s | byp_s;
  assign PCadd4_IF    = PC_IF + PC_STEP;
  assign push_s       = keep_s & ~(byp_s & ready_ID);
  assign pop_s        = ready_ID & ~empty_s;
  assign push_entry_s = '{pc: resp_pc_q, instr: IDATA};

  // Words still in flight at a redirect belong to the old path and get discarded.
  always_comb begin
    outst_d    = outst_q + CW'(issue_s) - CW'(IVALID);
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    if (redir_s) begin
      fetch_pc_d = target_s;
      resp_pc_d  = target_s;
      discard_d  = outst_d;
    end else begin
      if (issue_s) fetch_pc_d = fetch_pc_q + PC_STEP;
      else         fetch_pc_d = fetch_pc_q;
      if (keep_s)  resp_pc_d = resp_pc_q + PC_STEP;
      else         resp_pc_d = resp_pc_q;
      if (IVALID && (discard_q != '0)) discard_d = discard_q - CW'(1'b1);
      else                             discard_d = discard_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RSTN),
    .push_i  (push_s),
    .data_i  (push_entry_s),
    .pop_i   (pop_s),
    .flush_i (redir_s),
    .head_o  (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  fetch_fifo_chk u_chk (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .push_i (push_s),
    .full_i (full_s)
  );

endmodule

// File: doc/fetch_queue_if.md
# fetch_queue_if

Parametrised instruction-fetch stage with a decoupled prefetch queue. It keeps several instruction-memory requests in flight, buffers the returned words with their PCs, and feeds the ID stage through a valid/ready handshake. It also redirects on ID jumps and EX branches, discarding stale in-flight responses. It sits between the instruction memory port and the ID pipeline register and replaces the single-register PC fetch stage.

## Interface
- XLEN, 32, PC and instruction width
- IADDR_W, 30, instruction memory address width; IADDR = fetch PC[IADDR_W-1:0]
- DEPTH, 4, queue entries and maximum outstanding requests; power of two, ≥2
- RESET_PC, 32'h0, fetch PC after reset

- CLK  in  1  clock, all state on rising edge
- RSTN  in  1  asynchronous active-low reset
- redirect_ID  in  1  jump resolved in ID
- target_ID  in  XLEN  jump target
- redirect_EX  in  1  taken branch resolved in EX
- target_EX  in  XLEN  branch target
- IREQ  out  1  memory request valid
- IADDR  out  IADDR_W  request address
- IRDY  in  1  memory accepts request this cycle
- IVALID  in  1  response valid, in-order, one per accepted request
- IDATA  in  XLEN  response instruction
- valid_IF  out  1  queue head valid
- ready_ID  in  1  ID consumes head (low = stall)
- instr_IF  out  XLEN  head instruction
- PC_IF  out  XLEN  head PC
- PCadd4_IF  out  XLEN  PC_IF + 4

## Operation
- State: fetch_pc, FIFO of DEPTH entries {pc, instr}, outstanding counter (0..DEPTH), discard counter (0..DEPTH).
- Issue: IREQ = 1 when out of reset, no redirect this cycle, and count + outstanding < DEPTH. On IREQ & IRDY: fetch_pc += 4, outstanding++.
- Response: IVALID decrements outstanding. If discard > 0: drop word and decrement discard; else push {pc, IDATA}. Push PCs come from a response-PC register advanced by 4 per push and loaded with the target on redirect.
- Pop: valid_IF & ready_ID removes head. Push and pop in the same cycle leave count unchanged.
- Redirect priority: EX over ID (older instruction wins); ID ignored in the same cycle.
- On redirect: flush FIFO; fetch_pc and response-PC load the target. discard = outstanding after this cycle's issue/response updates. No IREQ that cycle. A same-cycle IVALID is dropped.
- Credit rule guarantees no overflow. A push to a full FIFO is an assertion failure.
- PC arithmetic is modulo 2^XLEN; wrap-around is silent.
- Handshake: while valid_IF & !ready_ID, instr_IF/PC_IF stay stable.

## Timing
- Reset values: IREQ 0, IADDR RESET_PC[IADDR_W-1:0], valid_IF 0, instr_IF 0, PC_IF 0, PCadd4_IF 4. fetch_pc = RESET_PC; counters 0.
- First IREQ: the first cycle after RSTN deasserts.
- Latency, IVALID to valid_IF: 1 cycle (registered FIFO), or 0 with bypass (see Configuration).
- Redirect at cycle N: valid_IF is 0 at N+1; IREQ for the target is at N+1; first target instruction is visible one cycle after its non-discarded IVALID.
- Reset mid-operation clears everything immediately. Responses to pre-reset requests are the memory's responsibility to suppress.

## Configuration
- FETCH_BYPASS_EN defined: when the FIFO is empty, discard = 0 and IVALID is high, IDATA and its PC drive the outputs combinationally with valid_IF = 1. If ready_ID is also high, the word is not pushed. Load-to-use of the fetch path is 0 cycles.
- Undefined: every response goes through the FIFO; no combinational path from IVALID/IDATA to outputs.

## Structure
- Package fetch_pkg: fetch_entry_t {pc, instr}, redirect-source enum {NONE, ID, EX}, default XLEN and RESET_PC constants.
- Sub-module fetch_fifo: synchronous FIFO parametrised by DEPTH and entry type, with push, pop, flush, count, full and empty outputs. Pointers wrap modulo DEPTH, and count uses $clog2(DEPTH)+1 bits.

## Test plan
- Reset, then IRDY=1 with 1-cycle IVALID and ready_ID=1 → IADDR 0, 4, 8, …; PC_IF 0, 4, 8 on consecutive cycles; PCadd4_IF = PC_IF+4.
- ready_ID=0 for 10 cycles → exactly DEPTH (4) requests issued, IREQ then low; head stays PC 0; releasing ready_ID drains 0, 4, 8, 12 in order.
- 3 requests outstanding, redirect_EX to 0x100 → 3 responses dropped; next PC_IF = 0x100; no stale word is visible.
- redirect_ID to 0x200 and redirect_EX to 0x300 in the same cycle → fetch resumes at 0x300.
- RSTN asserted mid-stream with 2 words queued → outputs go to reset values immediately; after release, fetch restarts at RESET_PC.
- With FETCH_BYPASS_EN, empty queue, IVALID with IDATA=0xDEADBEEF → valid_IF and instr_IF=0xDEADBEEF in the same cycle; count stays 0.
